// File: rtl/ray_row_collector.sv
// Scanline collector: arms the worker array, waits for every worker to finish,
// then streams the row's pixels in ascending x order to the line writer.
module ray_row_collector #(
   parameter int N_WORKERS        = 10,
   parameter int JOBS_SUBDIVISION = 64,
   parameter int COLOR_B          = 12,
   parameter int X_B              = 10,
   parameter int Y_B              = 9,
   parameter int ARM_TIMEOUT      = 16
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     start,
   input  logic [Y_B-1:0]                           row_y,
   input  logic [N_WORKERS-1:0]                     worker_busy,
   input  logic [N_WORKERS*JOBS_SUBDIVISION*COLOR_B-1:0] worker_buffer,
   output logic                                     activate,
   output logic                                     wr_valid,
   input  logic                                     wr_ready,
   output logic [X_B-1:0]                           wr_x,
   output logic [Y_B-1:0]                           wr_y,
   output logic [COLOR_B-1:0]                       wr_color,
   output logic                                     busy,
   output logic                                     row_done,
   output logic                                     arm_error,
   output logic [2:0]                               dbg_state
);

   localparam int ENTRIES = N_WORKERS * JOBS_SUBDIVISION;
   localparam int W_W     = (N_WORKERS > 1) ? $clog2(N_WORKERS) : 1;
   localparam int K_W     = (JOBS_SUBDIVISION > 1) ? $clog2(JOBS_SUBDIVISION) : 1;
   localparam int E_W     = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
   localparam int T_W     = $clog2(ARM_TIMEOUT + 1);
   localparam logic [X_B-1:0] LAST_X = X_B'(ENTRIES - 1);
   localparam logic [W_W-1:0] LAST_W = W_W'(N_WORKERS - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ARM       = 3'd1,
      S_WAIT_DONE = 3'd2,
      S_DRAIN     = 3'd3,
      S_RELEASE   = 3'd4
   } state_t;

   state_t               state;
   logic [W_W-1:0]       w_cnt;
   logic [K_W-1:0]       k_cnt;
   logic [T_W-1:0]       timer;
   logic [COLOR_B-1:0]   entry [ENTRIES];
   logic [E_W-1:0]       entry_idx;
   logic [COLOR_B-1:0]   next_color;
   logic                 accept;
   logic                 load_pixel;

   for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
      assign entry[i] = worker_buffer[i*COLOR_B +: COLOR_B];
   end

   // (w_cnt, k_cnt) always names the next pixel to be presented.
   assign entry_idx  = E_W'(w_cnt) * E_W'(JOBS_SUBDIVISION) + E_W'(k_cnt);
   assign next_color = entry[entry_idx];

   // Handshake: a pixel transfers on a clock edge where wr_valid && wr_ready;
   // while wr_valid is high and wr_ready low, wr_x/wr_color/wr_y hold steady.
   assign accept     = wr_valid && wr_ready;
   assign load_pixel = (state == S_DRAIN) && (!wr_valid || (accept && wr_x != LAST_X));
   assign dbg_state  = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         activate  <= 1'b0;
         wr_valid  <= 1'b0;
         busy      <= 1'b0;
         row_done  <= 1'b0;
         arm_error <= 1'b0;
         wr_x      <= '0;
         wr_y      <= '0;
         wr_color  <= '0;
         w_cnt     <= '0;
         k_cnt     <= '0;
         timer     <= '0;
      end else begin
         row_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  wr_y      <= row_y;
                  arm_error <= 1'b0;
                  timer     <= '0;
                  activate  <= 1'b1;
                  busy      <= 1'b1;
                  state     <= S_ARM;
               end
            end
            S_ARM: begin
               // All-ones wins over a timeout landing in the same cycle.
               if (&worker_busy) begin
                  state <= S_WAIT_DONE;
               end else if (timer == T_W'(ARM_TIMEOUT - 1)) begin
                  arm_error <= 1'b1;
                  activate  <= 1'b0;
                  busy      <= 1'b0;
                  state     <= S_IDLE;
               end else begin
                  timer <= timer + T_W'(1);
               end
            end
            S_WAIT_DONE: begin
               if (~|worker_busy) begin
                  w_cnt <= '0;
                  k_cnt <= '0;
                  state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (accept && wr_x == LAST_X) begin
                  wr_valid <= 1'b0;
                  activate <= 1'b0;
                  state    <= S_RELEASE;
               end else if (load_pixel) begin
                  wr_valid <= 1'b1;
                  wr_color <= next_color;
                  wr_x     <= wr_valid ? wr_x + X_B'(1) : '0;
                  if (w_cnt == LAST_W) begin
                     w_cnt <= '0;
                     k_cnt <= k_cnt + K_W'(1);
                  end else begin
                     w_cnt <= w_cnt + W_W'(1);
                  end
               end
            end
            S_RELEASE: begin
               row_done <= 1'b1;
               busy     <= 1'b0;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ray_row_collector.sv
// Directed bench for ray_row_collector: behavioural worker array, pixel monitor
// with in-order/stall checks, and latency checks around each row.
module tb_ray_row_collector;

   localparam int N   = 10;
   localparam int J   = 64;
   localparam int CB  = 12;
   localparam int XB  = 10;
   localparam int YB  = 9;
   localparam int AT  = 16;
   localparam int ENT = N * J;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [YB-1:0]     row_y;
   logic [N-1:0]      worker_busy;
   logic [ENT*CB-1:0] worker_buffer;
   logic              activate;
   logic              wr_valid;
   logic              wr_ready;
   logic [XB-1:0]     wr_x;
   logic [YB-1:0]     wr_y;
   logic [CB-1:0]     wr_color;
   logic              busy;
   logic              row_done;
   logic              arm_error;
   logic [2:0]        dbg_state;

   ray_row_collector #(
      .N_WORKERS(N), .JOBS_SUBDIVISION(J), .COLOR_B(CB),
      .X_B(XB), .Y_B(YB), .ARM_TIMEOUT(AT)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .row_y(row_y),
      .worker_busy(worker_busy), .worker_buffer(worker_buffer),
      .activate(activate), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color), .busy(busy),
      .row_done(row_done), .arm_error(arm_error), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // worker model state
   int act_cnt  [N];
   int clear_at [N];
   bit never_on [N];
   int cyc;
   int rdy_mode;
   int rdy_idx;
   int buf_xor;
   bit seen_ones;
   int zero_cyc;

   // pixel monitor state
   bit            mon_en;
   int            exp_x, exp_y, n_acc, last_acc_cyc, row_done_cyc, n_row_done;
   int            first_valid_cyc, act_rel;
   bit            prev_stall;
   logic [XB-1:0] prev_x;
   logic [CB-1:0] prev_color;
   logic [CB-1:0] col23;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic logic [CB-1:0] pix_color(input int x);
      int w, k;
      w = x % N;
      k = x / N;
      return CB'((w * J + k) ^ buf_xor);
   endfunction

   task automatic fill_buffer();
      for (int w = 0; w < N; w++)
         for (int k = 0; k < J; k++)
            worker_buffer[(w*J+k)*CB +: CB] = CB'((w * J + k) ^ buf_xor);
   endtask

   task automatic mon_reset();
      exp_x = 0; n_acc = 0; last_acc_cyc = -1; row_done_cyc = -1; n_row_done = 0;
      first_valid_cyc = -1; act_rel = -1; prev_stall = 0; col23 = '0;
      seen_ones = 0; zero_cyc = -1;
   endtask

   task automatic monitor();
      if (wr_valid) begin
         if (first_valid_cyc < 0) first_valid_cyc = cyc;
         if (prev_stall) begin
            check("stall_x", wr_x, prev_x);
            check("stall_color", wr_color, prev_color);
         end
         if (wr_ready) begin
            check("x_order", wr_x, exp_x);
            check("color", wr_color, pix_color(exp_x));
            check("wr_y", wr_y, exp_y);
            if (exp_x == 23) col23 = wr_color;
            exp_x++;
            n_acc++;
            last_acc_cyc = cyc;
         end
      end
      prev_stall = wr_valid && !wr_ready;
      prev_x     = wr_x;
      prev_color = wr_color;
      if (row_done) begin
         n_row_done++;
         if (row_done_cyc < 0) row_done_cyc = cyc;
      end
      if (last_acc_cyc >= 0 && cyc == last_acc_cyc + 1) act_rel = int'(activate);
   endtask

   // One cycle: move to the falling edge, update worker model and wr_ready
   // for the coming rising edge, then observe outputs.
   task automatic tick();
      @(negedge clk);
      cyc++;
      for (int w = 0; w < N; w++) begin
         if (!activate) begin
            act_cnt[w]     = 0;
            worker_busy[w] = 1'b0;
         end else begin
            act_cnt[w]++;
            worker_busy[w] = !never_on[w] && act_cnt[w] >= 2 && act_cnt[w] < clear_at[w];
         end
      end
      if (worker_busy == '1) seen_ones = 1;
      if (seen_ones && worker_busy == '0 && zero_cyc < 0) zero_cyc = cyc;
      wr_ready = (rdy_mode == 0) ? 1'b1 : ((rdy_idx % 4 == 0) || (rdy_idx % 4 == 3));
      rdy_idx++;
      if (mon_en) monitor();
   endtask

   task automatic run_row(input int y, input int mode, input int inject_at,
                          input int abort_x, output bit aborted);
      int start_cyc;
      mon_reset();
      exp_y    = y;
      row_y    = YB'(y);
      rdy_mode = mode;
      rdy_idx  = 0;
      mon_en   = 1;
      aborted  = 0;
      check("act_before_start", activate, 0);
      start     = 1'b1;
      start_cyc = cyc;
      tick();
      start = 1'b0;
      check("start_act_latency", activate, 1);
      check("start_busy", busy, 1);
      check("start_arm_err_clr", arm_error, 0);
      for (int b = 0; b < 5000 && row_done_cyc < 0; b++) begin
         tick();
         if (inject_at > 0 && cyc == start_cyc + inject_at) begin
            start = 1'b1;
            row_y = YB'(99);
         end else begin
            start = 1'b0;
         end
         if (abort_x >= 0 && wr_valid && wr_x == XB'(abort_x)) begin
            rst = 1'b1;
            #1;
            check("rst_activate", activate, 0);
            check("rst_wr_valid", wr_valid, 0);
            check("rst_busy", busy, 0);
            aborted = 1;
            break;
         end
      end
      start = 1'b0;
      if (!aborted) begin
         check("row_done_seen", row_done_cyc >= 0, 1);
         repeat (20) tick();
         check("accept_count", n_acc, 640);
         check("row_done_latency", row_done_cyc - last_acc_cyc, 2);
         check("release_activate", act_rel, 0);
         check("first_valid_latency", first_valid_cyc - zero_cyc, 2);
         check("row_done_count", n_row_done, 1);
         check("busy_after_row", busy, 0);
         check("activate_after_row", activate, 0);
         check("valid_after_row", wr_valid, 0);
      end
      mon_en = 0;
   endtask

   initial begin
      bit ab;
      rst = 1'b1; start = 1'b0; row_y = '0; worker_busy = '0; wr_ready = 1'b1;
      buf_xor = 0; cyc = 0; mon_en = 0; rdy_mode = 0; rdy_idx = 0;
      for (int w = 0; w < N; w++) begin
         act_cnt[w] = 0; clear_at[w] = 902; never_on[w] = 0;
      end
      fill_buffer();
      mon_reset();

      // reset state
      tick(); tick();
      check("rst_state", dbg_state, 0);
      check("rst_activate0", activate, 0);
      check("rst_wr_valid0", wr_valid, 0);
      check("rst_busy0", busy, 0);
      check("rst_row_done0", row_done, 0);
      check("rst_arm_error0", arm_error, 0);
      check("rst_wr_x0", wr_x, 0);
      check("rst_wr_y0", wr_y, 0);
      check("rst_wr_color0", wr_color, 0);
      rst = 1'b0;
      repeat (3) tick();
      check("idle_ready_no_valid", wr_valid, 0);

      // basic row
      run_row(17, 0, 0, -1, ab);
      check("color_x23", col23, 194);

      // backpressure 1,0,0,1 with a different buffer pattern
      buf_xor = 12'h5A5;
      fill_buffer();
      run_row(33, 1, 0, -1, ab);
      buf_xor = 0;
      fill_buffer();

      // arm timeout: worker 3 never asserts busy
      never_on[3] = 1;
      mon_reset();
      exp_y = 5; row_y = YB'(5); rdy_mode = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      mon_en = 1;
      repeat (15) tick();
      check("arm_last_cycle_act", activate, 1);
      check("arm_last_cycle_err", arm_error, 0);
      tick();
      check("arm_timeout_err", arm_error, 1);
      check("arm_timeout_act", activate, 0);
      check("arm_timeout_busy", busy, 0);
      repeat (30) tick();
      check("arm_timeout_no_valid", first_valid_cyc, -1);
      check("arm_timeout_no_row_done", n_row_done, 0);
      check("arm_error_sticky", arm_error, 1);
      mon_en = 0;
      never_on[3] = 0;

      // next start clears arm_error; a start during WAIT_DONE is ignored
      run_row(21, 0, 50, -1, ab);

      // async reset mid-drain at x=300, then a clean full row
      run_row(40, 0, 0, 300, ab);
      check("abort_reached", ab, 1);
      mon_en = 1;
      tick(); tick();
      rst = 1'b0;
      repeat (5) tick();
      check("rst_no_row_done", n_row_done, 0);
      check("rst_activate_low", activate, 0);
      mon_en = 0;
      run_row(41, 0, 0, -1, ab);

      // staggered finish 100..1000
      for (int w = 0; w < N; w++) clear_at[w] = 100 + w * 100;
      run_row(250, 0, 0, -1, ab);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ray_row_collector.md
Name: ray_row_collector

Overview:
- Consumer side of the raytracing worker array. Per scanline it raises `activate` to all workers and waits for every worker to finish its strided jobs.
- It then reads the workers' color buffers and streams the row's pixels in ascending x order to the line/frame buffer writer over a valid/ready interface.
- After the last pixel is accepted it drops `activate`, which returns the workers to READY for the next row.
- It sits between the worker array and the display memory.

Parameters:
- N_WORKERS, 10, number of workers; worker w owns pixels x = w + k*N_WORKERS.
- JOBS_SUBDIVISION, 64, color entries per worker buffer.
- COLOR_B, 12, bits per color (4:4:4).
- X_B, 10, width of the pixel x address; must hold N_WORKERS*JOBS_SUBDIVISION-1.
- Y_B, 9, width of the row index.
- ARM_TIMEOUT, 16, cycles allowed for all workers to assert busy after activate.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-high reset.
- start, in, 1, single-cycle request to render row `row_y`; sampled only in IDLE.
- row_y, in, Y_B, row index; latched on accepted start.
- worker_busy, in, N_WORKERS, busy flag of each worker.
- worker_buffer, in, N_WORKERS*JOBS_SUBDIVISION*COLOR_B, flattened buffers; entry (w,k) at bit offset (w*JOBS_SUBDIVISION+k)*COLOR_B.
- activate, out, 1, shared activate to all workers.
- wr_valid, out, 1, pixel write valid.
- wr_ready, in, 1, writer accepts the pixel when wr_valid && wr_ready.
- wr_x, out, X_B, pixel column.
- wr_y, out, Y_B, latched row.
- wr_color, out, COLOR_B, pixel color.
- busy, out, 1, high in every state except IDLE.
- row_done, out, 1, one-cycle pulse when a row completes.
- arm_error, out, 1, sticky; set on ARM timeout, cleared by the next accepted start or by rst.

Behaviour:
- Reset (async, on rst rising edge or while high): state=IDLE; activate, wr_valid, busy, row_done, arm_error = 0; wr_x, wr_y, wr_color = 0; internal counters = 0.
- IDLE:
  - start=1 → latch row_y into wr_y, clear arm_error, clear timer.
  - Next cycle: activate=1, state=ARM.
  - start in any other state is ignored.
- ARM: activate=1.
  - When worker_busy is all-ones → WAIT_DONE.
  - Timer increments each cycle; at ARM_TIMEOUT without all-ones → arm_error=1, activate=0, state=IDLE, no row_done.
  - The all-ones check takes priority over timeout in the same cycle.
- WAIT_DONE: activate=1.
  - When worker_busy is all-zeros → DRAIN, with w=0, k=0.
  - No timeout in this state.
- DRAIN: activate stays 1; workers hold their buffers in FINISHED while activate is high.
  - x is generated from counters w (0..N_WORKERS-1) and k (0..JOBS_SUBDIVISION-1). No divider.
  - Output registers: wr_x = k*N_WORKERS + w, maintained as a running counter incremented by 1; wr_color = buffer entry (w,k).
  - wr_valid rises the cycle after entering DRAIN. wr_x and wr_color hold stable while wr_valid && !wr_ready.
  - On accept: w+1; if w == N_WORKERS-1 then w=0, k+1. Next pixel is presented in the following cycle with no bubble, giving 1 pixel/cycle at sustained wr_ready.
  - On accept of x = N_WORKERS*JOBS_SUBDIVISION-1 (639): wr_valid=0, state=RELEASE.
- RELEASE: activate=0 for one cycle, then row_done=1 for one cycle and state=IDLE; busy falls together with the row_done pulse.
- Latency: start → activate is 1 cycle. All-zeros busy observed → first wr_valid is 2 cycles. Last accept → row_done is 2 cycles.
- Worker busy regressing to non-zero during DRAIN: ignored; buffers are read regardless.
- wr_ready held high through IDLE has no effect; wr_valid is never asserted outside DRAIN.
- Reset mid-DRAIN: activate and wr_valid drop asynchronously; no row_done.

Test Plan:
- Basic row: start with row_y=17; model workers go busy 1 cycle after activate and clear 900 cycles later; buffer(w,k)=w*64+k; wr_ready=1 → 640 writes wr_x=0..639 in order, wr_color at x=23 equals 3*64+2=194, wr_y=17 throughout; row_done exactly 2 cycles after the x=639 accept; activate low for the RELEASE cycle.
- Backpressure: wr_ready toggles 1,0,0,1 repeating → no pixel skipped or duplicated, wr_x/wr_color stable during stalls, 640 accepts total.
- Arm timeout: one worker never asserts busy → arm_error=1 after 16 ARM cycles, activate=0, no wr_valid, no row_done; next start clears arm_error.
- Ignored start: pulse start during WAIT_DONE with row_y=99 → wr_y unchanged, only one row emitted.
- Async reset mid-DRAIN at x=300: activate, wr_valid, busy go 0 immediately; a following start emits a full row again from x=0.
- Staggered finish: workers clear busy at different cycles (100..1000) → DRAIN entered only after the last clears; first wr_valid 2 cycles after all-zeros.
